// File: rtl/tlul_arb_pkg.sv
// Arbiter-local types: FSM state encoding, timeout error data and response opcode helper.
package tlul_arb_pkg;
    import tlul_pkg::*;

    typedef enum logic [1:0] {IDLE, GRANT, RESP, TOERR} arb_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic logic [2:0] resp_opcode(input logic [2:0] a_op);
        return (a_op == Get) ? AccessAckData : AccessAck;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel structs and opcode encodings shared by hosts, arbiter and device.
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_arb_rr2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to ptr_i.
module tlul_arb_rr2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    assign gnt_idx_o = (req_i == 2'b11) ? ptr_i : req_i[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
        assign gnt_o[gi] = req_i[gi] & (gnt_idx_o == 1'(gi));
    end

endmodule

// File: rtl/tlul_arb2_ctrl.sv
// Two-host TL-UL arbiter with a single outstanding transaction and a device timeout
// that answers the owning host with a locally generated error response.
module tlul_arb2_ctrl
    import tlul_pkg::*;
    import tlul_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h0_i,
    output tl_d2h_t tl_h0_o,
    input  tl_h2d_t tl_h1_i,
    output tl_d2h_t tl_h1_o,
    output tl_h2d_t tl_dev_o,
    input  tl_d2h_t tl_dev_i,
    output logic    owner_o,
    output logic    busy_o,
    output logic    timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_e       state_q;
    logic             owner_q;
    logic             rr_ptr_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [7:0]       src_q;
    logic [1:0]       size_q;

    tl_h2d_t host_req [2];
    tl_d2h_t host_rsp [2];
    tl_h2d_t own_h2d;
    tl_d2h_t owned_rsp;
    logic [1:0] gnt;
    logic       gnt_idx;

    assign host_req[0] = tl_h0_i;
    assign host_req[1] = tl_h1_i;
    assign own_h2d     = host_req[owner_q];

    tlul_arb_rr2 u_rr2 (
        .req_i     ({tl_h1_i.a_valid, tl_h0_i.a_valid}),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_ptr_q  <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            op_q      <= '0;
            src_q     <= '0;
            size_q    <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        owner_q <= gnt_idx;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    // A host withdrawing its request mid-grant forfeits the slot without moving the pointer.
                    if (!own_h2d.a_valid) begin
                        state_q <= IDLE;
                    end else if (tl_dev_i.a_ready) begin
                        op_q    <= own_h2d.a_opcode;
                        src_q   <= own_h2d.a_source;
                        size_q  <= own_h2d.a_size;
                        cnt_q   <= '0;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (tl_dev_i.d_valid) begin
                        if (own_h2d.d_ready) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= ~owner_q;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= TOERR;
                        timeout_q <= 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                TOERR: begin
                    if (own_h2d.d_ready) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= ~owner_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outside RESP the device D-channel is always drained so stale responses never reach a host.
    always_comb begin
        tl_dev_o         = '0;
        tl_dev_o.d_ready = 1'b1;
        owned_rsp        = '0;
        case (state_q)
            GRANT: begin
                tl_dev_o           = own_h2d;
                tl_dev_o.d_ready   = 1'b1;
                owned_rsp.a_ready  = tl_dev_i.a_ready;
            end
            RESP: begin
                tl_dev_o.d_ready   = own_h2d.d_ready;
                owned_rsp          = tl_dev_i;
                owned_rsp.a_ready  = 1'b0;
            end
            TOERR: begin
                owned_rsp.d_valid  = 1'b1;
                owned_rsp.d_error  = 1'b1;
                owned_rsp.d_opcode = resp_opcode(op_q);
                owned_rsp.d_source = src_q;
                owned_rsp.d_size   = size_q;
                owned_rsp.d_data   = (op_q == Get) ? ERR_DATA : 32'h0;
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign host_rsp[gi] = (owner_q == 1'(gi)) ? owned_rsp : '0;
    end

    assign tl_h0_o   = host_rsp[0];
    assign tl_h1_o   = host_rsp[1];
    assign owner_o   = owner_q;
    assign busy_o    = (state_q != IDLE);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_tlul_arb2_ctrl.sv
// Directed bench: two scripted hosts and a small register-file device model behind the arbiter.
module tb_tlul_arb2_ctrl;
    import tlul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tl_h2d_t h_in [2];
    tl_d2h_t h_out [2];
    tl_h2d_t dev_o;
    tl_d2h_t dev_in;
    logic    owner, busy, timeout;

    int checks = 0;
    int errors = 0;

    tlul_arb2_ctrl #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .tl_h0_i   (h_in[0]),
        .tl_h0_o   (h_out[0]),
        .tl_h1_i   (h_in[1]),
        .tl_h1_o   (h_out[1]),
        .tl_dev_o  (dev_o),
        .tl_dev_i  (dev_in),
        .owner_o   (owner),
        .busy_o    (busy),
        .timeout_o (timeout)
    );

    // Device: 4-word register file, one outstanding request, response can be stalled.
    logic        pending, stall;
    logic [2:0]  p_op;
    logic [7:0]  p_src;
    logic [1:0]  p_size;
    logic [31:0] p_data;
    logic [31:0] mem [4];

    always_comb begin
        dev_in          = '0;
        dev_in.a_ready  = !pending;
        dev_in.d_valid  = pending && !stall;
        dev_in.d_opcode = (p_op == Get) ? AccessAckData : AccessAck;
        dev_in.d_source = p_src;
        dev_in.d_size   = p_size;
        dev_in.d_data   = p_data;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (pending) begin
            if (!stall && dev_o.d_ready) pending <= 1'b0;
        end else if (dev_o.a_valid) begin
            pending <= 1'b1;
            p_op    <= dev_o.a_opcode;
            p_src   <= dev_o.a_source;
            p_size  <= dev_o.a_size;
            p_data  <= (dev_o.a_opcode == Get) ? mem[dev_o.a_address[3:2]] : 32'h0;
            if (dev_o.a_opcode != Get) mem[dev_o.a_address[3:2]] <= dev_o.a_data;
        end
    end

    // Monitor: grant order, timeout pulses and any activity seen by host 1.
    int   grant_log [$];
    int   to_pulses = 0;
    int   h1_act = 0;
    logic prev_busy = 1'b0;

    always begin
        @(negedge clk);
        #2;
        if (busy && !prev_busy) grant_log.push_back(int'(owner));
        prev_busy = busy;
        if (timeout) to_pulses++;
        if (h_out[1].a_ready || h_out[1].d_valid) h1_act++;
    end

    task automatic host_txn(input int h, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic [2:0] rop, output logic rerr, output logic [7:0] rsrc,
                            output int wait_cyc, output int lat, output bit ok);
        ok = 1'b0; rdata = '0; rop = '0; rerr = 1'b0; rsrc = '0; wait_cyc = 0; lat = 0;
        h_in[h].a_valid   = 1'b1;
        h_in[h].a_opcode  = op;
        h_in[h].a_address = addr;
        h_in[h].a_data    = wdata;
        h_in[h].a_mask    = 4'hF;
        h_in[h].a_size    = 2'd2;
        h_in[h].a_source  = (h == 0) ? 8'h10 : 8'h21;
        #1;
        while (!h_out[h].a_ready && wait_cyc < 200) begin
            @(negedge clk); #1; wait_cyc++;
        end
        if (h_out[h].a_ready) begin
            @(negedge clk);
            h_in[h].a_valid = 1'b0;
            #1;
            while (!h_out[h].d_valid && lat < 100) begin
                @(negedge clk); #1; lat++;
            end
            if (h_out[h].d_valid) begin
                rdata = h_out[h].d_data;
                rop   = h_out[h].d_opcode;
                rerr  = h_out[h].d_error;
                rsrc  = h_out[h].d_source;
                ok    = 1'b1;
            end
        end else begin
            h_in[h].a_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || owner !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy/owner/timeout got %b%b%b expected 000", busy, owner, timeout);
        end
        checks++;
        if (h_out[0].a_ready !== 1'b0 || h_out[0].d_valid !== 1'b0 ||
            h_out[1].a_ready !== 1'b0 || h_out[1].d_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_host_outputs: h0 ar/dv=%b%b h1 ar/dv=%b%b expected all 0",
                     h_out[0].a_ready, h_out[0].d_valid, h_out[1].a_ready, h_out[1].d_valid);
        end
        checks++;
        if (dev_o.a_valid !== 1'b0 || dev_o.d_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_dev: a_valid=%b d_ready=%b expected a_valid=0 d_ready=1",
                     dev_o.a_valid, dev_o.d_ready);
        end
        $display("test_reset: status and channel outputs at reset checked");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_put_get();
        logic [31:0] d; logic [2:0] op; logic e; logic [7:0] s; int w, l; bit ok;
        h1_act = 0;
        host_txn(0, PutFullData, 32'h0, 32'h1234_5678, d, op, e, s, w, l, ok);
        checks++;
        if (!ok || w != 1 || e !== 1'b0 || op !== AccessAck) begin
            errors++;
            $display("FAIL put_h0: ok=%0d wait=%0d err=%b op=%0d expected ok=1 wait=1 err=0 op=0", ok, w, e, op);
        end
        $display("h0 put 0x0 <- 0x12345678: wait=%0d op=%0d err=%b", w, op, e);
        host_txn(0, Get, 32'h0, 32'h0, d, op, e, s, w, l, ok);
        checks++;
        if (!ok || d !== 32'h1234_5678 || op !== AccessAckData || e !== 1'b0 || l != 0) begin
            errors++;
            $display("FAIL get_h0: ok=%0d data=%h op=%0d err=%b lat=%0d expected data=12345678 op=1 err=0 lat=0",
                     ok, d, op, e, l);
        end
        $display("h0 get 0x0 -> %h lat=%0d", d, l);
        checks++;
        if (h1_act != 0) begin
            errors++;
            $display("FAIL h1_isolated: h1 active cycles got %0d expected 0", h1_act);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d0, d1; logic [2:0] o0, o1; logic e0, e1; logic [7:0] s0, s1;
        int w0, w1, l0, l1; bit ok0, ok1;
        host_txn(1, PutFullData, 32'h4, 32'hCAFE_0004, d1, o1, e1, s1, w1, l1, ok1);
        $display("h1 put 0x4 <- 0xCAFE0004: ok=%0d", ok1);
        grant_log.delete();
        fork
            host_txn(0, Get, 32'h4, 32'h0, d0, o0, e0, s0, w0, l0, ok0);
            host_txn(1, Get, 32'h4, 32'h0, d1, o1, e1, s1, w1, l1, ok1);
        join
        $display("simultaneous get 0x4: h0=%h h1=%h grants=%0d", d0, d1, grant_log.size());
        checks++;
        if (grant_log.size() != 2) begin
            errors++;
            $display("FAIL sim_grant_count: got %0d expected 2", grant_log.size());
        end else if (grant_log[0] != 0 || grant_log[1] != 1) begin
            errors++;
            $display("FAIL sim_grant_order: got %0d,%0d expected 0,1", grant_log[0], grant_log[1]);
        end
        checks++;
        if (!ok0 || !ok1 || d0 !== 32'hCAFE_0004 || d1 !== 32'hCAFE_0004) begin
            errors++;
            $display("FAIL sim_data: h0=%h h1=%h expected cafe0004 for both", d0, d1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd1 [4];
        bit ok_all [2];
        ok_all[0] = 1'b1; ok_all[1] = 1'b1;
        grant_log.delete();
        fork
            begin
                logic [31:0] d; logic [2:0] op; logic e; logic [7:0] s; int w, l; bit ok;
                for (int i = 0; i < 4; i++) begin
                    host_txn(0, PutFullData, 32'h4, 32'hFFFF_FF01 + 32'(i), d, op, e, s, w, l, ok);
                    if (!ok) ok_all[0] = 1'b0;
                end
            end
            begin
                logic [2:0] op; logic e; logic [7:0] s; int w, l; bit ok;
                for (int j = 0; j < 4; j++) begin
                    host_txn(1, Get, 32'h4, 32'h0, rd1[j], op, e, s, w, l, ok);
                    if (!ok) ok_all[1] = 1'b0;
                end
            end
        join
        checks++;
        if (!ok_all[0] || !ok_all[1]) begin
            errors++;
            $display("FAIL b2b_complete: h0 ok=%0d h1 ok=%0d expected 1 1", ok_all[0], ok_all[1]);
        end
        checks++;
        if (grant_log.size() != 8) begin
            errors++;
            $display("FAIL b2b_grant_count: got %0d expected 8", grant_log.size());
        end
        for (int k = 0; k < grant_log.size() && k < 8; k++) begin
            checks++;
            if (grant_log[k] != (k % 2)) begin
                errors++;
                $display("FAIL b2b_grant_%0d: got owner %0d expected %0d", k, grant_log[k], k % 2);
            end
        end
        for (int k = 0; k < 4; k++) begin
            $display("b2b round %0d: h1 read %h", k, rd1[k]);
            checks++;
            if (rd1[k] !== 32'hFFFF_FF01 + 32'(k)) begin
                errors++;
                $display("FAIL b2b_read_%0d: got %h expected %h", k, rd1[k], 32'hFFFF_FF01 + 32'(k));
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic [2:0] op; logic e; logic [7:0] s; int w, l; bit ok;
        stall = 1'b1;
        to_pulses = 0;
        h1_act = 0;
        host_txn(0, Get, 32'h0, 32'h0, d, op, e, s, w, l, ok);
        @(negedge clk);
        @(negedge clk);
        $display("timeout get: ok=%0d lat=%0d err=%b data=%h op=%0d src=%h pulses=%0d",
                 ok, l, e, d, op, s, to_pulses);
        checks++;
        if (!ok || l != 16) begin
            errors++;
            $display("FAIL to_latency: ok=%0d got %0d RESP cycles expected 16", ok, l);
        end
        checks++;
        if (e !== 1'b1 || d !== 32'hDEAD_BEEF || op !== AccessAckData || s !== 8'h10) begin
            errors++;
            $display("FAIL to_response: err=%b data=%h op=%0d src=%h expected 1 deadbeef 1 10", e, d, op, s);
        end
        checks++;
        if (to_pulses != 1) begin
            errors++;
            $display("FAIL to_pulse: got %0d pulses expected 1", to_pulses);
        end
        checks++;
        if (h1_act != 0) begin
            errors++;
            $display("FAIL to_h1_isolated: got %0d active cycles expected 0", h1_act);
        end
    endtask

    task automatic test_late_response();
        logic [31:0] d; logic [2:0] op; logic e; logic [7:0] s; int w, l; bit ok;
        stall = 1'b0;
        #1;
        checks++;
        if (dev_in.d_valid !== 1'b1 || dev_o.d_ready !== 1'b1 ||
            h_out[0].d_valid !== 1'b0 || h_out[1].d_valid !== 1'b0) begin
            errors++;
            $display("FAIL late_absorb: dev dv=%b dr=%b h0 dv=%b h1 dv=%b expected 1 1 0 0",
                     dev_in.d_valid, dev_o.d_ready, h_out[0].d_valid, h_out[1].d_valid);
        end
        @(negedge clk);
        host_txn(1, Get, 32'h0, 32'h0, d, op, e, s, w, l, ok);
        $display("h1 get 0x0 after stray response -> %h err=%b", d, e);
        checks++;
        if (!ok || d !== 32'h1234_5678 || e !== 1'b0 || s !== 8'h21) begin
            errors++;
            $display("FAIL late_h1_get: ok=%0d data=%h err=%b src=%h expected 12345678 0 21", ok, d, e, s);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d0, d1; logic [2:0] o0, o1; logic e0, e1; logic [7:0] s0, s1;
        int w0, w1, l0, l1, n; bit ok0, ok1;
        host_txn(0, Get, 32'h0, 32'h0, d0, o0, e0, s0, w0, l0, ok0);
        stall = 1'b1;
        h_in[1].a_valid   = 1'b1;
        h_in[1].a_opcode  = Get;
        h_in[1].a_address = 32'h8;
        #1;
        n = 0;
        while (!h_out[1].a_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        h_in[1].a_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || owner !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_reset: busy=%b owner=%b expected 1 1", busy, owner);
        end
        rst = 1'b1;
        #1;
        $display("reset mid-RESP: busy=%b owner=%b timeout=%b", busy, owner, timeout);
        checks++;
        if (busy !== 1'b0 || owner !== 1'b0 || timeout !== 1'b0 ||
            h_out[1].d_valid !== 1'b0 || h_out[0].d_valid !== 1'b0 ||
            dev_o.a_valid !== 1'b0 || dev_o.d_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b owner=%b to=%b h0dv=%b h1dv=%b dav=%b ddr=%b expected 0 0 0 0 0 0 1",
                     busy, owner, timeout, h_out[0].d_valid, h_out[1].d_valid, dev_o.a_valid, dev_o.d_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        grant_log.delete();
        fork
            host_txn(0, Get, 32'h0, 32'h0, d0, o0, e0, s0, w0, l0, ok0);
            host_txn(1, Get, 32'h4, 32'h0, d1, o1, e1, s1, w1, l1, ok1);
        join
        $display("after reset: first grant=%0d h0 data=%h", (grant_log.size() > 0) ? grant_log[0] : -1, d0);
        checks++;
        if (grant_log.size() < 2 || grant_log[0] != 0) begin
            errors++;
            $display("FAIL post_reset_grant: log size %0d first %0d expected first grant 0",
                     grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
        end
        checks++;
        if (!ok0 || d0 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL post_reset_h0: ok=%0d data=%h expected 12345678", ok0, d0);
        end
    endtask

    initial begin
        h_in[0] = '0; h_in[0].d_ready = 1'b1;
        h_in[1] = '0; h_in[1].d_ready = 1'b1;
        stall = 1'b0;
        test_reset();
        test_put_get();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_late_response();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
